pb_flag_ctrl: RTL and testbench

//  Front end for the two timer pushbuttons (PB0 = increment minutes, PB1 = start/stop/clear).

---
 rtl/pb_flag_ctrl.sv | 129 ++++++++++++
 tb/tb_pb_flag_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pb_flag_ctrl.sv
// Pushbutton front end: per-button 2-flop sync, debounce FSM, sticky press flag with read handshake.
// Outputs: debounced pressed level and a press-pending flag per button.
module pb_flag_ctrl #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter bit          PB_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB0_raw,
  input  logic PB1_raw,
  input  logic PB0_read,
  input  logic PB1_read,
  output logic PB0_flag,
  output logic PB1_flag,
  output logic PB0_level,
  output logic PB1_level
);

  localparam int unsigned DB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned CNT_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [1:0] pb_raw;
  logic [1:0] pb_read;
  logic [1:0] pb_flag;
  logic [1:0] pb_level;

  assign pb_raw  = {PB1_raw, PB0_raw};
  assign pb_read = {PB1_read, PB0_read};

  assign PB0_flag  = pb_flag[0];
  assign PB1_flag  = pb_flag[1];
  assign PB0_level = pb_level[0];
  assign PB1_level = pb_level[1];

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic             pressed_raw;
    logic [1:0]       sync_q;
    logic             s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             set_c;
    logic             flag_q;
    logic             level_q;

    // Normalise polarity ahead of the synchronizer so its reset value means "released".
    assign pressed_raw = PB_ACTIVE_LOW ? ~pb_raw[i] : pb_raw[i];
    assign s           = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], pressed_raw};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      set_c   = 1'b0;
      case (state_q)
        RELEASED: begin
          if (s) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = RELEASED;
          end else if (cnt_q == CNT_MAX) begin
            state_d = PRESSED;
            set_c   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_d = PRESSED;
          end else if (cnt_q == CNT_MAX) begin
            state_d = RELEASED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = RELEASED;
      endcase
    end

    // A new press beats a same-cycle read so no press is ever dropped.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        flag_q  <= 1'b0;
        level_q <= 1'b0;
      end else begin
        if (set_c)           flag_q <= 1'b1;
        else if (pb_read[i]) flag_q <= 1'b0;
        level_q <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      end
    end

    assign pb_flag[i]  = flag_q;
    assign pb_level[i] = level_q;
  end

endmodule

// File: tb/tb_pb_flag_ctrl.sv
// Directed bench for pb_flag_ctrl with DB_CYCLES = 4, active-low buttons.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pb_flag_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic pb0_raw, pb1_raw, pb0_read, pb1_read;
  logic pb0_flag, pb1_flag, pb0_level, pb1_level;

  int n_assert = 0;
  int n_fail   = 0;

  pb_flag_ctrl #(
    .CLK_FREQ     (1000),
    .DEBOUNCE_MS  (4),
    .PB_ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .PB0_raw  (pb0_raw),
    .PB1_raw  (pb1_raw),
    .PB0_read (pb0_read),
    .PB1_read (pb1_read),
    .PB0_flag (pb0_flag),
    .PB1_flag (pb1_flag),
    .PB0_level(pb0_level),
    .PB1_level(pb1_level)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic f0, input logic l0,
                         input logic f1, input logic l1);
    chk({tag, " PB0_flag"},  pb0_flag,  f0);
    chk({tag, " PB0_level"}, pb0_level, l0);
    chk({tag, " PB1_flag"},  pb1_flag,  f1);
    chk({tag, " PB1_level"}, pb1_level, l1);
  endtask

  initial begin
    rst_n    = 1'b0;
    pb0_raw  = 1'b1;
    pb1_raw  = 1'b1;
    pb0_read = 1'b0;
    pb1_read = 1'b0;
    tick(2);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(3);
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 1: clean PB0 press, flag/level rise after edge 6
    pb0_raw = 1'b0;
    tick(6);
    chk_all("t1 edge5", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_all("t1 edge6", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(13);
    chk_all("t1 held", 1'b1, 1'b1, 1'b0, 1'b0);
    pb0_raw = 1'b1;
    tick(6);
    chk("t1 rel edge5 level", pb0_level, 1'b1);
    tick(1);
    chk("t1 rel edge6 level", pb0_level, 1'b0);
    chk("t1 rel no clear flag", pb0_flag, 1'b1);
    pb0_read = 1'b1;
    tick(1);
    pb0_read = 1'b0;
    chk("t1 read clears", pb0_flag, 1'b0);

    // 2: bounce shorter than debounce window
    repeat (5) begin
      pb0_raw = 1'b0;
      tick(3);
      pb0_raw = 1'b1;
      tick(3);
    end
    chk_all("t2 bounce", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);
    chk_all("t2 settle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: PB1 press, read at cycle 10, release, re-press
    pb1_raw = 1'b0;
    tick(7);
    chk("t3 flag set", pb1_flag, 1'b1);
    tick(3);
    pb1_read = 1'b1;
    tick(1);
    pb1_read = 1'b0;
    chk("t3 flag cleared", pb1_flag, 1'b0);
    chk("t3 level held", pb1_level, 1'b1);
    pb1_raw = 1'b1;
    tick(7);
    chk("t3 released level", pb1_level, 1'b0);
    chk("t3 release no flag", pb1_flag, 1'b0);
    pb1_raw = 1'b0;
    tick(7);
    chk("t3 repress flag", pb1_flag, 1'b1);
    pb1_read = 1'b1;
    tick(1);
    pb1_read = 1'b0;
    chk("t3 repress cleared", pb1_flag, 1'b0);
    pb1_raw = 1'b1;
    tick(7);
    chk("t3 final level", pb1_level, 1'b0);

    // 4: read coinciding with set edge keeps the flag
    pb0_raw = 1'b0;
    tick(7);
    chk("t4 first flag", pb0_flag, 1'b1);
    pb0_raw = 1'b1;
    tick(7);
    chk("t4 released", pb0_level, 1'b0);
    pb0_raw = 1'b0;
    tick(6);
    chk("t4 pre-edge flag", pb0_flag, 1'b1);
    pb0_read = 1'b1;
    tick(1);
    pb0_read = 1'b0;
    chk("t4 set wins", pb0_flag, 1'b1);
    chk("t4 level", pb0_level, 1'b1);
    pb0_read = 1'b1;
    tick(1);
    pb0_read = 1'b0;
    chk("t4 next read clears", pb0_flag, 1'b0);
    pb0_raw = 1'b1;
    tick(7);
    chk("t4 released again", pb0_level, 1'b0);

    // 5: two presses without read merge into one flag
    pb0_raw = 1'b0;
    tick(7);
    pb0_raw = 1'b1;
    tick(7);
    pb0_raw = 1'b0;
    tick(7);
    chk("t5 merged flag", pb0_flag, 1'b1);
    pb0_raw = 1'b1;
    tick(7);
    chk("t5 level low", pb0_level, 1'b0);
    pb0_read = 1'b1;
    tick(1);
    pb0_read = 1'b0;
    chk("t5 single read clears", pb0_flag, 1'b0);
    pb0_read = 1'b1;
    tick(1);
    pb0_read = 1'b0;
    chk("t5 read on zero flag", pb0_flag, 1'b0);

    // 6: reset during PB1 PRESS_WAIT, with PB0 flagged and held
    pb0_raw = 1'b0;
    tick(7);
    chk("t6 pb0 armed", pb0_flag, 1'b1);
    pb1_raw = 1'b0;
    tick(4);
    chk("t6 pb1 pending", pb1_flag, 1'b0);
    rst_n = 1'b0;
    #2;
    chk_all("t6 async reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk_all("t6 in reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(6);
    chk_all("t6 edge5", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_all("t6 edge6", 1'b1, 1'b1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
